// File: rtl/brami_wr_pacer.sv
// rtl/brami_wr_pacer.sv - buffers a pixel write stream and re-issues it as spaced write strobes
// Guarantees the BRAM arbiter never sees write strobes closer than MIN_GAP cycles.
module brami_wr_pacer #(
   parameter int RAM_WIDTH  = 16,
   parameter int RAM_DEPTH  = 320*240,
   parameter int FIFO_DEPTH = 8,
   parameter int MIN_GAP    = 2,
   localparam int AW = $clog2(RAM_DEPTH),
   localparam int PW = $clog2(FIFO_DEPTH),
   localparam int CW = PW + 1
) (
   input  logic                 clk_in,
   input  logic                 rst_in,
   input  logic                 valid_in,
   input  logic [AW-1:0]        addr_in,
   input  logic [RAM_WIDTH-1:0] data_in,
   output logic                 ready_out,
   output logic                 valid_wr_out,
   output logic [AW-1:0]        addr_wr_out,
   output logic [RAM_WIDTH-1:0] data_wr_out,
   output logic [CW-1:0]        count_out
);

   localparam int GW = (MIN_GAP > 1) ? $clog2(MIN_GAP) : 1;
   localparam int EW = AW + RAM_WIDTH;
   localparam logic [GW-1:0] GAP_RELOAD = GW'(MIN_GAP - 1);
   localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);

   logic [EW-1:0] mem [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [CW-1:0] count;
   logic [CW-1:0] count_next;
   logic [GW-1:0] gap_cnt;
   logic          push;
   logic          pop;

   // push is gated by the registered ready, so count can never exceed FIFO_DEPTH
   assign push = valid_in && ready_out;
   assign pop  = (count != '0) && (gap_cnt == '0);

   always_comb begin
      count_next = count;
      case ({push, pop})
         2'b10:   count_next = count + CW'(1);
         2'b01:   count_next = count - CW'(1);
         default: count_next = count;
      endcase
   end

   // storage is not reset; stale entries are unreachable once the pointers clear
   always_ff @(posedge clk_in) begin
      if (push) begin
         mem[wr_ptr] <= {addr_in, data_in};
      end
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         ready_out <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
         count     <= count_next;
         ready_out <= (count_next < FULL_COUNT);
      end
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         gap_cnt      <= '0;
         valid_wr_out <= 1'b0;
         addr_wr_out  <= '0;
         data_wr_out  <= '0;
      end else if (pop) begin
         gap_cnt                      <= GAP_RELOAD;
         valid_wr_out                 <= 1'b1;
         {addr_wr_out, data_wr_out}   <= mem[rd_ptr];
      end else begin
         valid_wr_out <= 1'b0;
         if (gap_cnt != '0) begin
            gap_cnt <= gap_cnt - GW'(1);
         end
      end
   end

   assign count_out = count;

endmodule

// File: tb/tb_brami_wr_pacer.sv
// tb/tb_brami_wr_pacer.sv - randomized, model-checked bench for brami_wr_pacer
// Two instances: MIN_GAP=2 (index 0) and MIN_GAP=1 (index 1).
module tb_brami_wr_pacer;

   localparam int DW    = 16;
   localparam int AW    = 17;
   localparam int CW    = 4;
   localparam int DEPTH = 8;

   logic clk_in = 1'b0;
   logic rst_n;
   always #5 clk_in = ~clk_in;

   logic          vin [2];
   logic [AW-1:0] ain [2];
   logic [DW-1:0] din [2];
   logic          rdy [2];
   logic          vwr [2];
   logic [AW-1:0] awr [2];
   logic [DW-1:0] dwr [2];
   logic [CW-1:0] cnt [2];

   int  checks = 0;
   int  errors = 0;
   bit  chk_en = 1'b0;
   int  tick   = 0;
   int  stall_total = 0;

   always @(posedge clk_in) tick <= tick + 1;

   task automatic check(input string name, input int g, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s[%0d] actual=%0h required=%0h at %0t", name, g, act, exp, $time);
      end
   endtask

   for (genvar g = 0; g < 2; g++) begin : inst
      localparam int MG = (g == 0) ? 2 : 1;

      brami_wr_pacer #(
         .RAM_WIDTH(DW), .RAM_DEPTH(320*240), .FIFO_DEPTH(DEPTH), .MIN_GAP(MG)
      ) dut (
         .clk_in(clk_in), .rst_in(rst_n), .valid_in(vin[g]), .addr_in(ain[g]),
         .data_in(din[g]), .ready_out(rdy[g]), .valid_wr_out(vwr[g]),
         .addr_wr_out(awr[g]), .data_wr_out(dwr[g]), .count_out(cnt[g])
      );

      // model: queue of words plus the edge index of the last issue
      logic [AW+DW-1:0] mq [$];
      int            cyc = 0;
      int            last_iss = -100;
      bit            m_rdy = 1'b0;
      bit            m_v = 1'b0;
      bit            do_pop;
      bit            do_push;
      logic [AW-1:0] m_a = '0;
      logic [DW-1:0] m_d = '0;
      logic [AW+DW-1:0] iss_q [$];
      int            iss_t [$];

      always @(posedge clk_in or negedge rst_n) begin
         if (!rst_n) begin
            mq.delete();
            m_rdy = 1'b0; m_v = 1'b0; m_a = '0; m_d = '0;
            cyc = 0; last_iss = -100;
         end else begin
            do_pop  = (mq.size() > 0) && ((cyc - last_iss) >= MG);
            do_push = vin[g] && m_rdy;
            m_v = do_pop;
            if (do_pop) begin
               {m_a, m_d} = mq.pop_front();
               last_iss = cyc;
            end
            if (do_push) mq.push_back({ain[g], din[g]});
            m_rdy = (mq.size() < DEPTH);
            cyc++;
         end
      end

      always @(negedge clk_in) begin
         if (chk_en) begin
            check("ready", g, 64'(rdy[g]), 64'(m_rdy));
            check("valid_wr", g, 64'(vwr[g]), 64'(m_v));
            check("addr_wr", g, 64'(awr[g]), 64'(m_a));
            check("data_wr", g, 64'(dwr[g]), 64'(m_d));
            check("count", g, 64'(cnt[g]), 64'(mq.size()));
         end
         if (vwr[g] === 1'b1) begin
            iss_q.push_back({awr[g], dwr[g]});
            iss_t.push_back(tick);
         end
      end
   end

   task automatic push_word(input int g, input int a, input int d, input int idle);
      int t = 0;
      repeat (idle) @(negedge clk_in);
      vin[g] = 1'b1; ain[g] = AW'(a); din[g] = DW'(d);
      while (rdy[g] !== 1'b1 && t < 200) begin
         check("stall_count", g, 64'(cnt[g]), 64'(DEPTH));
         stall_total++;
         @(negedge clk_in);
         t++;
      end
      checks++;
      if (t >= 200) begin
         errors++;
         $display("FAIL push_timeout[%0d] actual=%0d cycles required=<200", g, t);
      end
      @(negedge clk_in);
      vin[g] = 1'b0;
   endtask

   task automatic drain(input int g);
      int t = 0;
      while (cnt[g] !== '0 && t < 400) begin
         @(negedge clk_in);
         t++;
      end
      checks++;
      if (t >= 400) begin
         errors++;
         $display("FAIL drain_timeout[%0d] actual=%0d cycles required=<400", g, t);
      end
      repeat (3) @(negedge clk_in);
   endtask

   int b;
   logic [AW+DW-1:0] w;

   initial begin
      rst_n = 1'b1;
      for (int g = 0; g < 2; g++) begin
         vin[g] = 1'b0; ain[g] = '0; din[g] = '0;
      end
      #2 rst_n = 1'b0;
      #1 chk_en = 1'b1;
      @(negedge clk_in);
      @(negedge clk_in);
      for (int g = 0; g < 2; g++) begin
         check("rst_ready", g, 64'(rdy[g]), 64'd0);
         check("rst_valid", g, 64'(vwr[g]), 64'd0);
         check("rst_count", g, 64'(cnt[g]), 64'd0);
         check("rst_addr", g, 64'(awr[g]), 64'd0);
      end
      rst_n = 1'b1;
      @(negedge clk_in);
      check("ready_after_release", 0, 64'(rdy[0]), 64'd1);

      // T1 single word: strobe the cycle after accept
      push_word(0, 5, 16'hABCD, 0);
      check("t1_count_after_accept", 0, 64'(cnt[0]), 64'd1);
      check("t1_no_bypass", 0, 64'(vwr[0]), 64'd0);
      @(negedge clk_in);
      check("t1_strobe", 0, 64'(vwr[0]), 64'd1);
      check("t1_addr", 0, 64'(awr[0]), 64'd5);
      check("t1_data", 0, 64'(dwr[0]), 64'hABCD);
      @(negedge clk_in);
      check("t1_one_cycle", 0, 64'(vwr[0]), 64'd0);
      check("t1_addr_hold", 0, 64'(awr[0]), 64'd5);
      drain(0);

      // T2 burst of 8 with MIN_GAP=2
      b = inst[0].iss_q.size();
      for (int i = 0; i < 8; i++) push_word(0, i, $urandom_range(65535), 0);
      drain(0);
      check("t2_strobes", 0, 64'(inst[0].iss_q.size() - b), 64'd8);
      for (int i = 0; i < 8; i++) begin
         w = inst[0].iss_q[b+i];
         check("t2_addr_order", 0, 64'(w[AW+DW-1:DW]), 64'(i));
      end
      for (int i = 0; i < 7; i++)
         check("t2_spacing", 0, 64'(inst[0].iss_t[b+i+1] - inst[0].iss_t[b+i]), 64'd2);

      // T3 overflow: 20 back-to-back words
      b = inst[0].iss_q.size();
      stall_total = 0;
      for (int i = 0; i < 20; i++) push_word(0, 100 + i, 16'h1000 + i, 0);
      drain(0);
      check("t3_saw_backpressure", 0, 64'(stall_total > 0), 64'd1);
      check("t3_strobes", 0, 64'(inst[0].iss_q.size() - b), 64'd20);
      for (int i = 0; i < 20; i++) begin
         w = inst[0].iss_q[b+i];
         check("t3_word", 0, 64'(w), 64'({AW'(100 + i), DW'(16'h1000 + i)}));
      end

      // T4 async reset mid-burst, between clock edges
      for (int i = 0; i < 12; i++) push_word(0, 200 + i, i, 0);
      #2 rst_n = 1'b0;
      #1;
      check("t4_valid_immediate", 0, 64'(vwr[0]), 64'd0);
      check("t4_count_immediate", 0, 64'(cnt[0]), 64'd0);
      check("t4_ready_immediate", 0, 64'(rdy[0]), 64'd0);
      check("t4_addr_immediate", 0, 64'(awr[0]), 64'd0);
      check("t4_data_immediate", 0, 64'(dwr[0]), 64'd0);
      @(negedge clk_in);
      @(negedge clk_in);
      rst_n = 1'b1;
      b = inst[0].iss_q.size();
      @(negedge clk_in);
      check("t4_count_after", 0, 64'(cnt[0]), 64'd0);
      repeat (10) @(negedge clk_in);
      check("t4_no_stale", 0, 64'(inst[0].iss_q.size() - b), 64'd0);

      // T5 MIN_GAP=1: one word per cycle
      b = inst[1].iss_q.size();
      for (int i = 0; i < 8; i++) push_word(1, i, $urandom_range(65535), 0);
      drain(1);
      check("t5_strobes", 1, 64'(inst[1].iss_q.size() - b), 64'd8);
      for (int i = 0; i < 8; i++) begin
         w = inst[1].iss_q[b+i];
         check("t5_addr_order", 1, 64'(w[AW+DW-1:DW]), 64'(i));
      end
      for (int i = 0; i < 7; i++)
         check("t5_spacing", 1, 64'(inst[1].iss_t[b+i+1] - inst[1].iss_t[b+i]), 64'd1);

      // T6 edge address, then randomized traffic wrapping the pointers several times
      b = inst[0].iss_q.size();
      push_word(0, 76799, 16'hFFFF, 0);
      drain(0);
      check("t6_edge_word", 0, 64'(inst[0].iss_q[b]), 64'({AW'(76799), 16'hFFFF}));
      for (int g = 0; g < 2; g++) begin
         for (int i = 0; i < 40; i++)
            push_word(g, $urandom_range(76799), $urandom_range(65535),
                      ($urandom_range(3) == 0) ? $urandom_range(2) : 0);
         drain(g);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
